// File: rtl/reg_file_mp.sv
// Multi-port integer register file with a pending-write busy scoreboard.
// Optional same-cycle write-to-read bypass under macro REG_FILE_BYPASS_EN.
module reg_file_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  input  logic                wa_en,
  input  logic [AW-1:0]       wa_addr,
  input  logic [XLEN-1:0]     wa_data,
  input  logic                wa_clr,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                wb_clr,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0]  mem_q [NREGS-1:1];
  logic [XLEN-1:0]  mem_d [NREGS-1:1];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [AW-1:0]    ra [NRD];

  for (genvar g = 0; g < NRD; g++) begin : g_ra
    assign ra[g] = rd_addr[g*AW +: AW];
  end

  // Next storage: port A then port B, so B wins on a collision.
  always_comb begin
    mem_d = mem_q;
    for (int i = 1; i < NREGS; i++) begin
      if (wa_en && wa_addr == AW'(i)) mem_d[i] = wa_data;
      if (wb_en && wb_addr == AW'(i)) mem_d[i] = wb_data;
    end
  end

  // Next busy bits: clears first, then issue so set wins.
  always_comb begin
    busy_d    = busy_q;
    busy_d[0] = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      if (wa_en && wa_clr && wa_addr == AW'(i)) busy_d[i] = 1'b0;
      if (wb_en && wb_clr && wb_addr == AW'(i)) busy_d[i] = 1'b0;
      if (iss_valid && iss_addr == AW'(i))      busy_d[i] = 1'b1;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q  <= '{default: '0};
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  // Read ports: stored value (r0 reads 0), optional bypass.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int i = 1; i < NREGS; i++) begin
        if (ra[p] == AW'(i)) rd_data[p*XLEN +: XLEN] = mem_q[i];
      end
      rd_busy[p] = busy_q[ra[p]];
`ifdef REG_FILE_BYPASS_EN
      if (!reset && ra[p] != '0) begin
        if (wa_en && wa_addr == ra[p]) rd_data[p*XLEN +: XLEN] = wa_data;
        if (wb_en && wb_addr == ra[p]) rd_data[p*XLEN +: XLEN] = wb_data;
        if (((wa_en && wa_clr && wa_addr == ra[p]) ||
             (wb_en && wb_clr && wb_addr == ra[p])) &&
            !(iss_valid && iss_addr == ra[p]))
          rd_busy[p] = 1'b0;
      end
`endif
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp (XLEN=64, NREGS=16, NRD=3): reference model
// compared every negedge plus directed literal checks.
module tb_reg_file_mp;
  localparam int XLEN  = 64;
  localparam int NREGS = 16;
  localparam int NRD   = 3;
  localparam int AW    = 4;
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clock = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic                wa_en, wb_en, wa_clr, wb_clr;
  logic [AW-1:0]       wa_addr, wb_addr;
  logic [XLEN-1:0]     wa_data, wb_data;
  logic [NREGS-1:0]    busy_vec;

  int checks = 0;
  int failures = 0;

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clock(clock), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data), .wa_clr(wa_clr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_clr(wb_clr),
    .busy_vec(busy_vec)
  );

  always #5 clock = ~clock;

  // Reference model: plain arrays updated from the architectural rules.
  logic [XLEN-1:0]  m_mem [NREGS];
  logic [NREGS-1:0] m_busy;

  initial begin
    for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
    m_busy = '0;
  end

  always @(posedge reset) begin
    for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
    m_busy = '0;
  end

  always @(posedge clock) begin
    if (!reset) begin
      if (wa_en && wa_addr != 0) m_mem[wa_addr] = wa_data;
      if (wb_en && wb_addr != 0) m_mem[wb_addr] = wb_data;
      if (wa_en && wa_clr) m_busy[wa_addr] = 1'b0;
      if (wb_en && wb_clr) m_busy[wb_addr] = 1'b0;
      if (iss_valid) m_busy[iss_addr] = 1'b1;
      m_busy[0] = 1'b0;
    end
  end

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    if (reset || a == 0) return '0;
    if (BYP && wb_en && wb_addr == a) return wb_data;
    if (BYP && wa_en && wa_addr == a) return wa_data;
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    logic hit_clr;
    if (reset) return 1'b0;
    hit_clr = (wa_en && wa_clr && wa_addr == a) ||
              (wb_en && wb_clr && wb_addr == a);
    if (BYP && hit_clr && !(iss_valid && iss_addr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] rd(input int p);
    return rd_data[p*XLEN +: XLEN];
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    for (int p = 0; p < NRD; p++) begin
      check($sformatf("rd_data%0d", p), rd(p), exp_data(rd_addr[p*AW +: AW]));
      check($sformatf("rd_busy%0d", p), 64'(rd_busy[p]),
            64'(exp_busy(rd_addr[p*AW +: AW])));
    end
    check("busy_vec", 64'(busy_vec), 64'(m_busy));
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wa_en = 0; wb_en = 0; wa_clr = 0; wb_clr = 0; iss_valid = 0;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  initial begin
    reset = 0; rd_addr = '0; iss_addr = '0;
    wa_addr = '0; wb_addr = '0; wa_data = '0; wb_data = '0;
    idle();
    #1 reset = 1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_rd0", rd(0), 64'h0);
    check("reset_busy", 64'(busy_vec), 64'h0);
    reset = 0;

    // r5 write plus r6 issue, then async reset mid-cycle
    cyc(); idle();
    wa_en = 1; wa_addr = 5; wa_data = 64'hDEADBEEF;
    iss_valid = 1; iss_addr = 6; set_rd(0, 5);
    cyc(); idle(); #2;
    check("r5_written", rd(0), 64'hDEADBEEF);
    check("r6_busy", 64'(busy_vec), 64'h0040);
    reset = 1; #1;
    check("async_rst_r5", rd(0), 64'h0);
    check("async_rst_busy", 64'(busy_vec), 64'h0);
    cyc(); cyc(); reset = 0;

    // zero register
    cyc(); idle();
    wa_en = 1; wa_addr = 0; wa_data = 64'h1234; wa_clr = 1;
    iss_valid = 1; iss_addr = 0; set_rd(0, 0); #2;
    check("r0_same", rd(0), 64'h0);
    cyc(); idle(); #2;
    check("r0_next", rd(0), 64'h0);
    check("r0_busy", 64'(busy_vec), 64'h0);

    // write collision on r7
    wa_en = 1; wa_addr = 7; wa_data = 64'h11;
    wb_en = 1; wb_addr = 7; wb_data = 64'h22; set_rd(1, 7); #2;
    check("coll_same", rd(1), BYP ? 64'h22 : 64'h0);
    cyc(); idle(); #2;
    check("coll_next", rd(1), 64'h22);

    // bypass on r3
    wa_en = 1; wa_addr = 3; wa_data = 64'hCAFE; set_rd(0, 3); #2;
    check("byp_same", rd(0), BYP ? 64'hCAFE : 64'h0);
    cyc(); idle(); #2;
    check("byp_next", rd(0), 64'hCAFE);

    // scoreboard on r9 (cycle 0 issue)
    set_rd(2, 9); iss_valid = 1; iss_addr = 9;
    cyc(); idle(); #2;
    check("sb_c1", 64'(rd_busy[2]), 64'h1);
    cyc(); idle();
    cyc(); idle();
    wb_en = 1; wb_clr = 1; wb_addr = 9; wb_data = 64'h99;
    iss_valid = 1; iss_addr = 9; #2;
    check("sb_c3", 64'(rd_busy[2]), 64'h1);
    cyc(); idle(); #2;
    check("sb_c4", 64'(rd_busy[2]), 64'h1);
    cyc(); idle();
    wa_en = 1; wa_clr = 1; wa_addr = 9; wa_data = 64'h98; #2;
    check("sb_c5", 64'(rd_busy[2]), BYP ? 64'h0 : 64'h1);
    cyc(); idle(); #2;
    check("sb_c6", 64'(rd_busy[2]), 64'h0);

    // clear without enable is ignored
    iss_valid = 1; iss_addr = 10;
    cyc(); idle();
    wa_clr = 1; wa_addr = 10; wb_clr = 1; wb_addr = 10;
    cyc(); idle(); #2;
    check("clr_no_en", 64'(busy_vec), 64'h0400);
    wb_en = 1; wb_clr = 1; wb_addr = 10;
    cyc(); idle(); #2;
    check("clr_en", 64'(busy_vec), 64'h0);

    // 64-bit data on three concurrent ports
    wb_en = 1; wb_addr = 1; wb_data = 64'hFFFF_0000_FFFF_0000;
    wa_en = 1; wa_addr = 2; wa_data = 64'h0123_4567_89AB_CDEF;
    cyc(); idle();
    wa_en = 1; wa_addr = 15; wa_data = 64'hA5A5_5A5A_0F0F_F0F0;
    cyc(); idle();
    set_rd(0, 1); set_rd(1, 2); set_rd(2, 15); #2;
    check("p0_r1", rd(0), 64'hFFFF_0000_FFFF_0000);
    check("p1_r2", rd(1), 64'h0123_4567_89AB_CDEF);
    check("p2_r15", rd(2), 64'hA5A5_5A5A_0F0F_F0F0);

    // mixed traffic, checked against the model each cycle
    for (int n = 0; n < 300; n++) begin
      cyc();
      iss_valid = 1'($urandom); iss_addr = AW'($urandom);
      wa_en = 1'($urandom); wa_clr = 1'($urandom);
      wa_addr = AW'($urandom); wa_data = {$urandom, $urandom};
      wb_en = 1'($urandom); wb_clr = 1'($urandom);
      wb_addr = AW'($urandom); wb_data = {$urandom, $urandom};
      rd_addr = NRD*AW'($urandom);
      if (n % 4 == 0) set_rd(0, wa_addr);
      if (n % 4 == 1) set_rd(1, wb_addr);
    end
    cyc(); idle();
    cyc();
    @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
